// File: rtl/mdu_e.sv
`default_nettype none
// ============================================================================
// Module   : mdu_e
// Purpose  : E-stage operand bypass mux plus multi-cycle multiply/divide
//            engine owning the architectural HI/LO registers.
// Ports    : clk, reset (sync, active-high)
//            RD1_E/RD2_E   register-file operands carried in the E register
//            AO_M/PC8_M    M-stage bypass sources, WD_W W-stage bypass source
//            ForwardRSE/ForwardRTE  operand select codes
//            md_op/md_start/md_cancel  engine request / flush
//            RS_E_fwd/RT_E_fwd  resolved operands to the ALU
//            HI/LO, md_busy (registered), md_stall (combinational)
// Revision : 1.0  initial release
// ============================================================================
module mdu_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] AO_M,
    input  logic [31:0] PC8_M,
    input  logic [31:0] WD_W,
    input  logic [1:0]  ForwardRSE,
    input  logic [1:0]  ForwardRTE,
    input  logic [2:0]  md_op,
    input  logic        md_start,
    input  logic        md_cancel,
    output logic [31:0] RS_E_fwd,
    output logic [31:0] RT_E_fwd,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        md_busy,
    output logic        md_stall
);

    localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;
    logic [31:0]         r_hi_p;
    logic [31:0]         r_lo_p;
    logic                r_busy;

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_is_md;

    // ------------------------------------------------------------------
    // Operand bypass
    // ------------------------------------------------------------------
    always_comb begin
        w_a = RD1_E;
        case (ForwardRSE)
            2'b00:   w_a = RD1_E;
            2'b01:   w_a = AO_M;
            2'b10:   w_a = PC8_M;
            default: w_a = WD_W;
        endcase
    end

    always_comb begin
        w_b = RD2_E;
        case (ForwardRTE)
            2'b00:   w_b = RD2_E;
            2'b01:   w_b = AO_M;
            2'b10:   w_b = PC8_M;
            default: w_b = WD_W;
        endcase
    end

    assign RS_E_fwd = w_a;
    assign RT_E_fwd = w_b;

    // ------------------------------------------------------------------
    // Result computed at accept time from the resolved operands
    // ------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_b_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_div_s;
    logic [31:0] w_div_u;
    logic [31:0] w_qs_mag;
    logic [31:0] w_rs_mag;
    logic [31:0] w_qs;
    logic [31:0] w_rs;
    logic [31:0] w_qu;
    logic [31:0] w_ru;
    logic [31:0] w_hi_res;
    logic [31:0] w_lo_res;

    assign w_prod_s = $signed({{32{w_a[31]}}, w_a}) * $signed({{32{w_b[31]}}, w_b});
    assign w_prod_u = {32'd0, w_a} * {32'd0, w_b};

    // Signed divide is done on magnitudes and the signs restored after.
    // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000
    // negates back to itself, remainder 0.
    assign w_b_zero = (w_b == 32'd0);
    assign w_a_mag  = w_a[31] ? (~w_a + 32'd1) : w_a;
    assign w_b_mag  = w_b[31] ? (~w_b + 32'd1) : w_b;
    // Divisor forced to 1 on divide-by-zero; that result is overridden below.
    assign w_div_s  = w_b_zero ? 32'd1 : w_b_mag;
    assign w_div_u  = w_b_zero ? 32'd1 : w_b;
    assign w_qs_mag = w_a_mag / w_div_s;
    assign w_rs_mag = w_a_mag % w_div_s;
    assign w_qs     = (w_a[31] ^ w_b[31]) ? (~w_qs_mag + 32'd1) : w_qs_mag;
    assign w_rs     = w_a[31] ? (~w_rs_mag + 32'd1) : w_rs_mag;
    assign w_qu     = w_a / w_div_u;
    assign w_ru     = w_a % w_div_u;

    always_comb begin
        w_hi_res = 32'd0;
        w_lo_res = 32'd0;
        case (md_op)
            c_OP_MULT:  {w_hi_res, w_lo_res} = w_prod_s;
            c_OP_MULTU: {w_hi_res, w_lo_res} = w_prod_u;
            c_OP_DIV: begin
                w_hi_res = w_b_zero ? w_a : w_rs;
                w_lo_res = w_b_zero ? 32'hFFFF_FFFF : w_qs;
            end
            c_OP_DIVU: begin
                w_hi_res = w_b_zero ? w_a : w_ru;
                w_lo_res = w_b_zero ? 32'hFFFF_FFFF : w_qu;
            end
            default: begin
                w_hi_res = 32'd0;
                w_lo_res = 32'd0;
            end
        endcase
    end

    assign w_is_md = (md_op >= c_OP_MULT) && (md_op <= c_OP_DIVU);

    // ------------------------------------------------------------------
    // Engine control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_hi_p  <= 32'd0;
            r_lo_p  <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A flush in the same cycle kills the request outright.
                    if (md_start && !md_cancel) begin
                        if (w_is_md) begin
                            r_hi_p  <= w_hi_res;
                            r_lo_p  <= w_lo_res;
                            r_cnt   <= (md_op <= c_OP_MULTU) ? c_CNT_W'(MULT_CYCLES)
                                                             : c_CNT_W'(DIV_CYCLES);
                            r_state <= S_BUSY;
                            r_busy  <= 1'b1;
                        end else if (md_op == c_OP_MTHI) begin
                            r_hi <= w_a;
                        end else if (md_op == c_OP_MTLO) begin
                            r_lo <= w_a;
                        end
                    end
                end
                S_BUSY: begin
                    // New requests are ignored here; the stall unit holds them.
                    if (md_cancel) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_hi_p  <= 32'd0;
                        r_lo_p  <= 32'd0;
                    end else if (r_cnt == c_CNT_W'(1)) begin
                        r_hi    <= r_hi_p;
                        r_lo    <= r_lo_p;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign HI       = r_hi;
    assign LO       = r_lo;
    assign md_busy  = r_busy;
    assign md_stall = r_busy | (md_start & w_is_md);

endmodule
`default_nettype wire

// File: tb/tb_mdu_e.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_e
// Purpose  : Self-checking bench for mdu_e. Expected HI/LO and latency are
//            queued when an operation is issued and compared when the engine
//            drops md_busy.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_e;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] RD1_E, RD2_E, AO_M, PC8_M, WD_W;
    logic [1:0]  ForwardRSE, ForwardRTE;
    logic [2:0]  md_op;
    logic        md_start, md_cancel;
    logic [31:0] RS_E_fwd, RT_E_fwd, HI, LO;
    logic        md_busy, md_stall;

    always #5 clk = ~clk;

    mdu_e #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .RD1_E     (RD1_E),
        .RD2_E     (RD2_E),
        .AO_M      (AO_M),
        .PC8_M     (PC8_M),
        .WD_W      (WD_W),
        .ForwardRSE(ForwardRSE),
        .ForwardRTE(ForwardRTE),
        .md_op     (md_op),
        .md_start  (md_start),
        .md_cancel (md_cancel),
        .RS_E_fwd  (RS_E_fwd),
        .RT_E_fwd  (RT_E_fwd),
        .HI        (HI),
        .LO        (LO),
        .md_busy   (md_busy),
        .md_stall  (md_stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi, m_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic using 64-bit integer semantics.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb_, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = 64'd0;
        case (op)
            3'd1: res = 64'(sa * sb_);
            3'd2: res = 64'(ua * ub);
            3'd3: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q   = sa / sb_;
                    r   = sa % sb_;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd4: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    uq  = ua / ub;
                    ur  = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    task automatic scramble();
        RD1_E = $urandom; RD2_E = $urandom;
        AO_M  = $urandom; PC8_M = $urandom; WD_W = $urandom;
    endtask

    // Issue one request from a negedge; A is routed through bypass source sel.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [1:0] sel);
        exp_t        e;
        logic [63:0] r;
        scramble();
        case (sel)
            2'd0: RD1_E = a;
            2'd1: AO_M  = a;
            2'd2: PC8_M = a;
            default: WD_W = a;
        endcase
        ForwardRSE = sel;
        RD2_E      = b;
        ForwardRTE = 2'b00;
        md_op      = op;
        md_start   = 1'b1;
        #1;
        check("stall_accept", {63'd0, md_stall}, {63'd0, (op >= 3'd1 && op <= 3'd4)});
        if (op >= 3'd1 && op <= 3'd4) begin
            r     = model(op, a, b);
            e.hi  = r[63:32];
            e.lo  = r[31:0];
            e.cyc = (op <= 3'd2) ? MULT_CYCLES : DIV_CYCLES;
            sb.push_back(e);
        end
        @(negedge clk);
        md_start = 1'b0;
        md_op    = 3'd0;
        if (op == 3'd5) m_hi = a;
        if (op == 3'd6) m_lo = a;
    endtask

    // kind: 0 none, 1 mthi(5) at cycle inj_at, 2 cancel, 3 reset
    task automatic wait_result(input int inj_at, input int kind);
        int   cyc;
        exp_t e;
        cyc = 0;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        while (md_busy === 1'b1 && cyc < 200) begin
            md_start  = 1'b0;
            md_cancel = 1'b0;
            reset     = 1'b0;
            md_op     = 3'd0;
            cyc++;
            check("hold", {HI, LO}, {m_hi, m_lo});
            scramble();
            if (cyc == inj_at) begin
                case (kind)
                    1: begin
                        ForwardRSE = 2'b00;
                        RD1_E      = 32'd5;
                        md_op      = 3'd5;
                        md_start   = 1'b1;
                    end
                    2: md_cancel = 1'b1;
                    3: reset = 1'b1;
                    default: ;
                endcase
            end
            @(negedge clk);
        end
        md_start  = 1'b0;
        md_cancel = 1'b0;
        reset     = 1'b0;
        md_op     = 3'd0;
        if (kind <= 1) begin
            check("latency", 64'(cyc), 64'(e.cyc));
            m_hi = e.hi;
            m_lo = e.lo;
        end else begin
            check("abort_latency", 64'(cyc), 64'(inj_at));
            if (kind == 3) begin
                m_hi = 32'd0;
                m_lo = 32'd0;
            end
        end
        check("hi", {32'd0, HI}, {32'd0, m_hi});
        check("lo", {32'd0, LO}, {32'd0, m_lo});
        check("busy_done", {63'd0, md_busy}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_rs[4];
        int          exp_rt[4];
        logic [2:0]  op;
        logic [31:0] a, b;

        reset = 1'b1; md_start = 1'b0; md_cancel = 1'b0; md_op = 3'd0;
        RD1_E = 0; RD2_E = 0; AO_M = 0; PC8_M = 0; WD_W = 0;
        ForwardRSE = 2'b00; ForwardRTE = 2'b00;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_hi", {32'd0, HI}, 64'd0);
        check("rst_lo", {32'd0, LO}, 64'd0);
        check("rst_busy", {63'd0, md_busy}, 64'd0);
        check("rst_stall", {63'd0, md_stall}, 64'd0);
        reset = 1'b0;

        // Bypass mux sweep
        RD1_E = 32'd1; AO_M = 32'd2; PC8_M = 32'd3; WD_W = 32'd4; RD2_E = 32'd5;
        exp_rs = '{1, 2, 3, 4};
        exp_rt = '{5, 2, 3, 4};
        for (int s = 0; s < 4; s++) begin
            ForwardRSE = 2'(s);
            ForwardRTE = 2'(s);
            #1;
            check("fwd_rs", {32'd0, RS_E_fwd}, 64'(exp_rs[s]));
            check("fwd_rt", {32'd0, RT_E_fwd}, 64'(exp_rt[s]));
        end
        @(negedge clk);

        // Directed arithmetic
        start_op(3'd1, 32'hFFFF_FFFE, 32'd3, 2'd0); wait_result(0, 0);
        check("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        start_op(3'd2, 32'hFFFF_FFFE, 32'd3, 2'd1); wait_result(0, 0);
        check("multu_const", {HI, LO}, 64'h0000_0002_FFFF_FFFA);
        start_op(3'd3, 32'hFFFF_FFF9, 32'd2, 2'd2); wait_result(0, 0);
        check("div_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        start_op(3'd4, 32'd7, 32'd0, 2'd3); wait_result(0, 0);
        check("divu_zero_const", {HI, LO}, 64'h0000_0007_FFFF_FFFF);
        start_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0); wait_result(0, 0);
        check("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);
        start_op(3'd3, 32'hFFFF_FF00, 32'd0, 2'd0); wait_result(0, 0);

        // mthi while busy is dropped
        start_op(3'd3, 32'd100, 32'd7, 2'd1); wait_result(3, 1);
        check("div_mid_mthi", {32'd0, HI}, 64'd2);

        // mthi / mtlo in idle
        start_op(3'd5, 32'd5, 32'd0, 2'd0);
        check("mthi_idle", {32'd0, HI}, 64'd5);
        check("mthi_busy", {63'd0, md_busy}, 64'd0);
        start_op(3'd6, 32'hA5A5_5A5A, 32'd0, 2'd2);
        check("mtlo_idle", {32'd0, LO}, {32'd0, m_lo});
        check("mtlo_hi_kept", {32'd0, HI}, 64'd5);

        // Cancel mid-multiply
        start_op(3'd1, 32'd1234, 32'd5678, 2'd0); wait_result(3, 2);

        // start with cancel in idle is ignored
        RD1_E = 32'd9; RD2_E = 32'd9; ForwardRSE = 2'b00; ForwardRTE = 2'b00;
        md_op = 3'd1; md_start = 1'b1; md_cancel = 1'b1;
        @(negedge clk);
        md_start = 1'b0; md_cancel = 1'b0; md_op = 3'd0;
        check("cancel_start_busy", {63'd0, md_busy}, 64'd0);
        @(negedge clk);
        check("cancel_start_hilo", {HI, LO}, {m_hi, m_lo});

        // Reset mid-divide, then a normal multiply
        start_op(3'd3, 32'd1000, 32'd3, 2'd0); wait_result(4, 3);
        start_op(3'd1, 32'd12345, 32'hFFFF_E57B, 2'd3); wait_result(0, 0);

        // Random operations through random bypass sources
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
            start_op(op, a, b, 2'($urandom_range(0, 3)));
            wait_result(0, 0);
        end

        if (sb.size() != 0) check("sb_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_e.md
Name: mdu_e

Overview:
- E-stage operand-bypass and multiply/divide unit.
- Sits directly downstream of the E-stage forwarding controller. It takes that controller's ForwardRSE/ForwardRTE select codes, resolves the rs/rt operands from the register file or the M/W bypass buses, and drives the resolved operands to the ALU.
- The same operands feed a multi-cycle multiply/divide engine. The engine owns the architectural HI/LO registers and raises a busy indication for the hazard/stall logic.

Parameters:
- MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO update (≥1)
- DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO update (≥1)

Ports:
- clk  input  1  single system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- RD1_E  input  32  rs value read in D, carried in E register
- RD2_E  input  32  rt value read in D, carried in E register
- AO_M  input  32  ALU/result value of the M-stage instruction
- PC8_M  input  32  PC+8 of the M-stage instruction (link value)
- WD_W  input  32  register write-back data of the W-stage instruction
- ForwardRSE  input  2  rs select: 00 RD1_E, 01 AO_M, 10 PC8_M, 11 WD_W
- ForwardRTE  input  2  rt select, same encoding, base RD2_E
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- md_start  input  1  one-cycle request qualifying md_op
- md_cancel  input  1  abort in-flight op (exception flush)
- RS_E_fwd  output  32  resolved rs operand to ALU
- RT_E_fwd  output  32  resolved rt operand to ALU
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- md_busy  output  1  engine computing
- md_stall  output  1  md_busy | (md_start & op in 1..4); consumed by the stall unit

Behaviour:
- Operand mux is purely combinational (0 latency) per select encoding. A, B = RS_E_fwd, RT_E_fwd.
- Reset: HI=0, LO=0, md_busy=0, counter=0, pending result regs=0. Reset mid-operation discards the operation; HI/LO end at 0.
- States:
  - IDLE: md_start with op 1..4 → latch result into pending hi_p/lo_p, load counter with MULT_CYCLES or DIV_CYCLES, go BUSY. Result is computed at accept from A/B, so later operand changes do not matter.
  - IDLE: md_start with op 5 → HI←A next edge. Op 6 → LO←A next edge. No busy is raised.
  - BUSY: counter decrements each cycle. When the counter equals 1, HI←hi_p, LO←lo_p at that edge and the state returns to IDLE.
  - Net effect: HI/LO visible exactly N cycles after the accept edge, and md_busy is high for exactly N cycles.
- md_start while BUSY: ignored entirely, including mthi/mtlo. The stall unit must hold those instructions.
- md_cancel in BUSY: return to IDLE next edge, HI/LO unchanged, pending discarded.
- md_cancel asserted together with md_start in IDLE: the start is ignored.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit A*B.
  - multu: unsigned 64-bit product.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero: LO=32'hFFFFFFFF, HI=A (both signed and unsigned).
- Signed overflow (A=32'h80000000, B=32'hFFFFFFFF): LO=32'h80000000, HI=0.
- md_busy is registered. md_stall is combinational so the accept cycle is also stalled.
- Implementation freedom: the engine may be implemented iteratively, provided the result and timing above are exact.

Test Plan:
- Forward mux: RD1_E=1, AO_M=2, PC8_M=3, WD_W=4; sweep ForwardRSE 00..11 → RS_E_fwd 1,2,3,4 same cycle. Repeat on rt.
- mult: A=32'hFFFFFFFE (−2), B=3, start at edge t → md_busy high t+1..t+5, HI=32'hFFFFFFFF, LO=32'hFFFFFFFA visible after edge t+5. Same operands with multu → HI=2, LO=32'hFFFFFFFA.
- div: A=−7, B=2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF after 10 cycles. divu with A=7, B=0 → LO=32'hFFFFFFFF, HI=7. div with A=32'h80000000, B=−1 → LO=32'h80000000, HI=0.
- Start during BUSY: issue mthi A=5 mid-divide → HI shows divide result only, never 5. Then mthi in IDLE → HI=5 next cycle, md_busy stays 0.
- Cancel: md_cancel at cycle 3 of a multiply → md_busy low next cycle, HI/LO keep prior values.
- Reset mid-divide: assert reset at cycle 4 → HI=LO=0, md_busy=0 next edge. A new mult accepted after reset completes normally.
